// File: rtl/nois_debug_pkg.sv
// Shared types and defaults for the sysclk-side debug command decoder.
package nois_debug_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam int DEF_IR_W       = 2;
  localparam int DEF_SR_W       = 38;
  localparam int DEF_ACTION_BIT = 35;

  // Queue entry layout at the default widths; wider builds use entry_w().
  typedef struct packed {
    logic [DEF_IR_W-1:0] ir;
    logic [DEF_SR_W-1:0] sr;
  } entry_t;

  function automatic int entry_w(input int ir_w, input int sr_w);
    return ir_w + sr_w;
  endfunction

endpackage

// File: rtl/nois_debug_cmd_sysclk_mc_if.sv
// JTAG-side inputs, CPU-side handshake and status of the debug command decoder.
// Handshake: a command is taken from the queue only in IDLE while cmd_ready is
// high; the dispatch then completes regardless of later cmd_ready changes.
interface nois_debug_cmd_sysclk_mc_if #(
  parameter int IR_W       = nois_debug_pkg::DEF_IR_W,
  parameter int SR_W       = nois_debug_pkg::DEF_SR_W,
  parameter int CH         = 4,
  parameter int FIFO_DEPTH = 4
) ();
  import nois_debug_pkg::*;

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [IR_W-1:0]  ir_in;
  logic [SR_W-1:0]  sr;
  logic             vs_uir;
  logic             vs_udr;
  logic             cmd_ready;
  logic             err_clr;
  logic [SR_W-1:0]  jdo;
  logic [IR_W-1:0]  ir_latched;
  logic [CH-1:0]    take_action;
  logic [CH-1:0]    take_no_action;
  logic             busy;
  logic [CNT_W-1:0] fifo_count;
  logic             overflow_err;
  logic             bad_ir_err;
  state_t           fsm_state;

  modport master (
    output ir_in, sr, vs_uir, vs_udr, cmd_ready, err_clr,
    input  jdo, ir_latched, take_action, take_no_action, busy, fifo_count,
           overflow_err, bad_ir_err, fsm_state
  );

  modport slave (
    input  ir_in, sr, vs_uir, vs_udr, cmd_ready, err_clr,
    output jdo, ir_latched, take_action, take_no_action, busy, fifo_count,
           overflow_err, bad_ir_err, fsm_state
  );

endinterface

// File: rtl/nois_debug_cmd_fifo.sv
// Synchronous FIFO with occupancy count; a push is accepted when full if a pop
// happens on the same edge.
module nois_debug_cmd_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [W-1:0]               wdata,
  output logic [W-1:0]               rdata,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/nois_debug_cmd_sysclk_mc.sv
// Sysclk-side debug command decoder: synchronises JTAG update strobes, queues
// update-DR commands and dispatches them as one-hot per-channel pulses.
module nois_debug_cmd_sysclk_mc
  import nois_debug_pkg::*;
#(
  parameter int IR_W        = DEF_IR_W,
  parameter int SR_W        = DEF_SR_W,
  parameter int CH          = 4,
  parameter int ACTION_BIT  = DEF_ACTION_BIT,
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2,
  parameter int HOLD_CYC    = 2
) (
  input  logic                        clk,
  input  logic                        reset_n,
  nois_debug_cmd_sysclk_mc_if.slave   bus
);

  localparam int EW    = entry_w(IR_W, SR_W);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int HC_W  = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
  localparam logic [HC_W-1:0] HOLD_LAST = HC_W'((HOLD_CYC > 0) ? HOLD_CYC - 1 : 0);

  logic [SYNC_STAGES-1:0] uir_sync;
  logic [SYNC_STAGES-1:0] udr_sync;
  logic                   uir_prev;
  logic                   udr_prev;
  logic                   uir_rise;
  logic                   udr_rise;

  logic [IR_W-1:0]  ir_q;
  logic [IR_W-1:0]  entry_ir;
  logic             ir_ok;

  logic [EW-1:0]    head;
  logic [EW-1:0]    cur;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             empty;
  logic             pop;

  state_t           state;
  state_t           state_next;
  logic [HC_W-1:0]  hold_cnt;

  logic [CH-1:0]    onehot;
  logic [CH-1:0]    ta_next;
  logic [CH-1:0]    tna_next;
  logic             jdo_load;
  logic [CH-1:0]    ta_q;
  logic [CH-1:0]    tna_q;
  logic [SR_W-1:0]  jdo_q;
  logic             ovf_q;
  logic             bad_q;
  logic             ovf_set;
  logic             bad_set;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      uir_sync <= '0;
      udr_sync <= '0;
      uir_prev <= 1'b0;
      udr_prev <= 1'b0;
    end else begin
      uir_sync <= {uir_sync[SYNC_STAGES-2:0], bus.vs_uir};
      udr_sync <= {udr_sync[SYNC_STAGES-2:0], bus.vs_udr};
      uir_prev <= uir_sync[SYNC_STAGES-1];
      udr_prev <= udr_sync[SYNC_STAGES-1];
    end
  end

  assign uir_rise = uir_sync[SYNC_STAGES-1] & ~uir_prev;
  assign udr_rise = udr_sync[SYNC_STAGES-1] & ~udr_prev;

  always_ff @(posedge clk) begin
    if (!reset_n)      ir_q <= '0;
    else if (uir_rise) ir_q <= bus.ir_in;
  end

  // A coincident update-IR must steer the command it arrives with.
  assign entry_ir = uir_rise ? bus.ir_in : ir_q;
  assign ir_ok    = ({1'b0, entry_ir} < (IR_W+1)'(CH));
  assign bad_set  = udr_rise & ~ir_ok;
  assign ovf_set  = udr_rise & ir_ok & full & ~pop;

  nois_debug_cmd_fifo #(
    .W     (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (udr_rise & ir_ok),
    .pop     (pop),
    .wdata   ({entry_ir, bus.sr}),
    .rdata   (head),
    .count   (count),
    .full    (full),
    .empty   (empty)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= IDLE;
      hold_cnt <= '0;
    end else begin
      state    <= state_next;
      hold_cnt <= (state == HOLD) ? hold_cnt + 1'b1 : '0;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (!empty && bus.cmd_ready) state_next = ISSUE;
      ISSUE:   state_next = (HOLD_CYC > 0) ? HOLD : IDLE;
      HOLD:    if (hold_cnt == HOLD_LAST) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    pop      = (state == IDLE) && !empty && bus.cmd_ready;
    jdo_load = (state == ISSUE);
    onehot   = CH'(1) << cur[EW-1 -: IR_W];
    ta_next  = '0;
    tna_next = '0;
    if (state == ISSUE) begin
      if (cur[ACTION_BIT]) ta_next  = onehot;
      else                 tna_next = onehot;
    end
  end

  // The popped head is parked in cur so ISSUE sees it after the pointer moves.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cur   <= '0;
      ta_q  <= '0;
      tna_q <= '0;
      jdo_q <= '0;
      ovf_q <= 1'b0;
      bad_q <= 1'b0;
    end else begin
      if (pop)      cur   <= head;
      if (jdo_load) jdo_q <= cur[SR_W-1:0];
      ta_q  <= ta_next;
      tna_q <= tna_next;
      if (ovf_set)          ovf_q <= 1'b1;
      else if (bus.err_clr) ovf_q <= 1'b0;
      if (bad_set)          bad_q <= 1'b1;
      else if (bus.err_clr) bad_q <= 1'b0;
    end
  end

  assign bus.jdo            = jdo_q;
  assign bus.ir_latched     = ir_q;
  assign bus.take_action    = ta_q;
  assign bus.take_no_action = tna_q;
  assign bus.busy           = ~empty | (state != IDLE);
  assign bus.fifo_count     = count;
  assign bus.overflow_err   = ovf_q;
  assign bus.bad_ir_err     = bad_q;
  assign bus.fsm_state      = state;

endmodule
